// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between CPU writeback, a debug writer and an init sweep (optional RF_X0_GUARD_EN keeps x0 unwritten)
module rf_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int INIT_INDEX   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              init_start,
  output logic              init_busy,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic              cpu_stall,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wd,
  output logic              dbg_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              rf_src_dbg
);
  typedef enum logic {SERVE, INIT} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W:0]   sweep_q, sweep_d, sweep_inc;
  logic [3:0]        starve_q, starve_d;
  logic              we_q, we_d, src_q, src_d;
  logic [ADDR_W-1:0] a3_q, a3_d, acc_addr;
  logic [DATA_W-1:0] wd_q, wd_d, acc_wd;
  logic              serve, force_dbg, cpu_take, dbg_take, x0_blk;
  assign serve     = state_q == SERVE;
  assign force_dbg = serve && dbg_valid && starve_q == 4'(STARVE_LIMIT);
  assign cpu_take  = serve && cpu_we && !force_dbg;
  assign dbg_take  = serve && dbg_valid && !cpu_take;
  assign acc_addr  = cpu_take ? cpu_addr : dbg_addr;
  assign acc_wd    = cpu_take ? cpu_wd : dbg_wd;
  assign sweep_inc = sweep_q + 1'b1;
`ifdef RF_X0_GUARD_EN
  assign x0_blk = acc_addr == '0;
`else
  assign x0_blk = 1'b0;
`endif
  assign cpu_stall  = cpu_we && !cpu_take;
  assign dbg_ready  = dbg_take;
  assign init_busy  = state_q == INIT;
  assign rf_we      = we_q;
  assign rf_a3      = a3_q;
  assign rf_wd3     = wd_q;
  assign rf_src_dbg = src_q;
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    starve_d = '0;
    we_d     = 1'b0;
    src_d    = 1'b0;
    a3_d     = a3_q;
    wd_d     = wd_q;
    if (serve) begin
      we_d     = (cpu_take || dbg_take) && !x0_blk;
      src_d    = dbg_take;
      a3_d     = (cpu_take || dbg_take) ? acc_addr : a3_q;
      wd_d     = (cpu_take || dbg_take) ? acc_wd : wd_q;
      starve_d = (cpu_take && dbg_valid) ? starve_q + 4'd1 : '0;
      state_d  = init_start ? INIT : SERVE;
    end else begin
      // sweep index 0 always writes 0, so the x0 guard needs no special case here
      we_d    = 1'b1;
      a3_d    = sweep_q[ADDR_W-1:0];
      wd_d    = (INIT_INDEX != 0) ? DATA_W'(sweep_q[ADDR_W-1:0]) : '0;
      sweep_d = sweep_inc[ADDR_W] ? '0 : sweep_inc;
      state_d = sweep_inc[ADDR_W] ? SERVE : INIT;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= SERVE;
      sweep_q  <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      src_q    <= 1'b0;
      a3_q     <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      src_q    <= src_d;
      a3_q     <= a3_d;
      wd_q     <= wd_d;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed and random stimulus against a cycle-level reference model
module tb_rf_write_arbiter;
  localparam int DW = 32, AW = 5, LIM = 4, II = 1, N = 32;
  logic CLK = 0, RST = 1, init_start = 0, cpu_we = 0, dbg_valid = 0;
  logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
  logic [DW-1:0] cpu_wd = '0, dbg_wd = '0;
  logic init_busy, cpu_stall, dbg_ready, rf_we, rf_src_dbg;
  logic [AW-1:0] rf_a3;
  logic [DW-1:0] rf_wd3;
  int n_chk = 0, n_pass = 0;
  bit m_busy, m_we, m_src, m_cpu, m_dbg;
  int m_idx, m_starve;
  int unsigned m_a3, m_wd;
  always #5 CLK = ~CLK;
  rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM), .INIT_INDEX(II)) dut (
    .CLK(CLK), .RST(RST), .init_start(init_start), .init_busy(init_busy),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd), .dbg_ready(dbg_ready),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_src_dbg(rf_src_dbg)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic bit blocked(input int a);
`ifdef RF_X0_GUARD_EN
    return a == 0;
`else
    return a < 0;
`endif
  endfunction
  task automatic cycle(input bit r, input bit ist, input bit cw, input int ca, input int unsigned cd,
                       input bit dv, input int da, input int unsigned dd);
    bit frc;
    int a;
    int unsigned d;
    RST = r; init_start = ist; cpu_we = cw; cpu_addr = ca[AW-1:0]; cpu_wd = cd;
    dbg_valid = dv; dbg_addr = da[AW-1:0]; dbg_wd = dd;
    #1;
    frc   = !m_busy && dv && m_starve == LIM;
    m_cpu = !m_busy && cw && !frc;
    m_dbg = !m_busy && dv && !m_cpu;
    check("cpu_stall", cpu_stall, cw && !m_cpu);
    check("dbg_ready", dbg_ready, m_dbg);
    if (r) begin
      m_busy = 0; m_idx = 0; m_starve = 0; m_we = 0; m_src = 0; m_a3 = 0; m_wd = 0;
    end else if (m_busy) begin
      m_we = 1; m_src = 0; m_a3 = m_idx; m_wd = II != 0 ? m_idx : 0; m_starve = 0;
      m_idx++;
      if (m_idx == N) begin m_busy = 0; m_idx = 0; end
    end else begin
      a = m_cpu ? ca : da;
      d = m_cpu ? cd : dd;
      m_we = (m_cpu || m_dbg) && !blocked(a);
      m_src = m_dbg;
      if (m_cpu || m_dbg) begin m_a3 = a; m_wd = d; end
      m_starve = (m_cpu && dv) ? (m_starve < LIM ? m_starve + 1 : LIM) : 0;
      m_busy = ist;
    end
    @(posedge CLK); #1;
    check("rf_we", rf_we, m_we);
    check("init_busy", init_busy, m_busy);
    if (m_we) begin
      check("rf_a3", rf_a3, m_a3);
      check("rf_wd3", rf_wd3, m_wd);
      check("rf_src_dbg", rf_src_dbg, m_src);
    end
  endtask
  initial begin
    bit cp, dp, r;
    int ca, da;
    int unsigned cd, dd;
    cp = 0; dp = 0; ca = 0; da = 0; cd = 0; dd = 0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_we", rf_we, 0);
    check("rst_a3", rf_a3, 0);
    check("rst_wd3", rf_wd3, 0);
    check("rst_src", rf_src_dbg, 0);
    check("rst_busy", init_busy, 0);
    check("rst_stall", cpu_stall, 0);
    check("rst_ready", dbg_ready, 0);
    cycle(0, 0, 1, 5, 'hDEAD, 0, 0, 0);
    check("t1_we", rf_we, 1);
    check("t1_a3", rf_a3, 5);
    check("t1_wd3", rf_wd3, 'hDEAD);
    check("t1_src", rf_src_dbg, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1, i + 1, 100 + i, 1, 9, 'h99);
      check("t2_src", rf_src_dbg, (i % 5) == 4);
    end
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < N; k++) begin
      cycle(0, k == 5, 1, 3, 'h5, 1, 2, 'h6);
      check("t3_a3", rf_a3, k);
      check("t3_wd3", rf_wd3, k);
      check("t3_busy", init_busy, k < N - 1);
    end
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    check("t4_we", rf_we, 0);
    check("t4_busy", init_busy, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      check("t4_idle_we", rf_we, 0);
    end
    cycle(0, 0, 0, 0, 0, 1, 0, 7);
`ifdef RF_X0_GUARD_EN
    check("t6_we", rf_we, 0);
`else
    check("t6_we", rf_we, 1);
    check("t6_a3", rf_a3, 0);
    check("t6_wd3", rf_wd3, 7);
`endif
    for (int i = 0; i < 3000; i++) begin
      if (!cp && $urandom_range(0, 2) != 0) begin cp = 1; ca = $urandom_range(0, 31); cd = $urandom; end
      if (!dp && $urandom_range(0, 2) != 0) begin dp = 1; da = $urandom_range(0, 31); dd = $urandom; end
      r = $urandom_range(0, 299) == 0;
      cycle(r, $urandom_range(0, 59) == 0, cp, ca, cd, dp, da, dd);
      if (m_cpu || r) cp = 0;
      if (m_dbg || r) dp = 0;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
